fft_peak_detect: RTL and testbench
==================================

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 The block SHALL have parameter LOG2_BINS, default 4, meaning log2 of bins per frame; the frame length is 2^LOG2_BINS = 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port fft_valid, input, 1 bit: qualifies fft_d_in for the current cycle.
REQ-005 The block SHALL have port fft_d_in, input, 32 bits: {real[31:16], imag[15:0]}, each half signed two's complement.
REQ-006 The block SHALL have port done, output, 1 bit: one-cycle pulse that marks the completed frame result.
REQ-007 The block SHALL have port freq, output, LOG2_BINS bits: bin index of the peak magnitude.
REQ-008 The block SHALL have port peak_mag, output, 32 bits unsigned: re^2+im^2 of the peak bin.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is partially received or in the pipeline.

Function
REQ-010 The block SHALL accept bins in index order 0..15, one per cycle when fft_valid=1; idle cycles between bins are allowed and ignored.
REQ-011 The block SHALL hold a 4-bit bin counter that increments on each accepted word and wraps 15->0; the counter value is the bin index.
REQ-012 Stage 1 SHALL register re*re and im*im as 32-bit unsigned values, together with the bin index and a last flag (index==15).
REQ-013 Stage 2 SHALL sum the two squares into a 32-bit unsigned value; the maximum, 2^31 at (-32768,-32768), SHALL not overflow.
REQ-014 Stage 2 SHALL compare the sum against the running max; bin 0 SHALL load unconditionally.
REQ-015 A later bin SHALL replace the running max only if its sum is strictly greater, so ties keep the lowest index.
REQ-016 On the stage-2 cycle of bin 15, freq and peak_mag SHALL load the final winner (including bin 15 itself) and done SHALL pulse high next cycle for exactly one cycle.
REQ-017 Latency SHALL be exactly 2 cycles from bin 15 accepted (edge N) to done=1 in cycle N+2.
REQ-018 freq and peak_mag SHALL hold their value until the next done.
REQ-019 The block SHALL accept back-to-back frames with zero gap: bin 0 of frame k+1 may arrive in the cycle after bin 15 of frame k, and it SHALL restart the running max without disturbing frame k's result.
REQ-020 The state machine SHALL have states IDLE (counter 0, pipe empty), COLLECT (0 < counter or pipe valid) and FLUSH (bin 15 in pipe); busy = (state != IDLE).
REQ-021 The state machine SHALL transition IDLE->COLLECT on an accepted word.
REQ-022 The state machine SHALL transition COLLECT->FLUSH when bin 15 is accepted.
REQ-023 The state machine SHALL transition FLUSH->IDLE after done if no new word was accepted; otherwise FLUSH->COLLECT.
REQ-024 The block SHALL have no timeout; a partial frame waits indefinitely.

Reset
REQ-025 rst SHALL clear the counter, pipeline valids, running max and state (to IDLE) immediately; done=0, freq=0, peak_mag=0, busy=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; the first word accepted after release is bin 0.
REQ-027 fft_valid while rst is high SHALL be ignored.

Structure
REQ-028 The shared FAS package SHALL hold FFT_BINS=16, LOG2_BINS=4, the sample width 16, and the {real,imag} packing field positions.
REQ-029 The block SHALL use one sub-module, fft_mag_sq, that holds the two registered squarers and the adder; compare, counter and FSM SHALL stay in fft_peak_detect.

Verification
REQ-030 Single tone: bin 5 = {16'd1000,16'd0}, all other bins 0, consecutive cycles -> done 2 cycles after bin 15, freq=5, peak_mag=1000000.
REQ-031 Tie: bins 3 and 9 = {16'd0,16'sd-200}, others {16'd10,16'd10} -> freq=3, peak_mag=40000.
REQ-032 Extreme: bin 15 = {16'h8000,16'h8000} -> freq=15, peak_mag=32'h8000_0000, no wrap.
REQ-033 Gaps/back-to-back: frame A (peak at bin 2) sent with random idle cycles, immediately followed by frame B (peak at bin 12) -> two done pulses, freq=2 then 12, freq holds 2 between them.
REQ-034 Reset mid-frame: rst pulse after bin 7, then full frame with peak at bin 1 -> exactly one done, freq=1; busy=0 during rst.

Source files
------------

// File: rtl/fft_peak_detect_pkg.sv
// Shared constants and types for the FFT peak detector: frame geometry,
// sample width, {real,imag} packing and the frame-tracking FSM states.
package fft_peak_detect_pkg;

  localparam int FFT_BINS  = 16;
  localparam int LOG2_BINS = 4;
  localparam int SAMPLE_W  = 16;
  localparam int DATA_W    = 2 * SAMPLE_W;

  // Field positions inside one packed FFT word
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Registered squarers for one FFT bin plus the unsigned adder that forms
// re^2 + im^2; bin index, last flag and valid travel alongside.
module fft_mag_sq
  import fft_peak_detect_pkg::*;
#(
  parameter int IDX_W = LOG2_BINS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [31:0]       out_sum
);

  logic signed [SAMPLE_W-1:0] re_s;
  logic signed [SAMPLE_W-1:0] im_s;
  logic signed [31:0]         re_ext;
  logic signed [31:0]         im_ext;

  logic [31:0]      sq_re_d, sq_re_q;
  logic [31:0]      sq_im_d, sq_im_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             last_d, last_q;
  logic             valid_d, valid_q;

  always_comb begin
    re_s    = in_data[RE_MSB:RE_LSB];
    im_s    = in_data[IM_MSB:IM_LSB];
    re_ext  = 32'(re_s);
    im_ext  = 32'(im_s);
    sq_re_d = sq_re_q;
    sq_im_d = sq_im_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = in_valid;
    // Each square is at most 2^30, so it is non-negative and fits unsigned
    if (in_valid) begin
      sq_re_d = re_ext * re_ext;
      sq_im_d = im_ext * im_ext;
      idx_d   = in_idx;
      last_d  = in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_re_q <= '0;
      sq_im_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sq_re_q <= sq_re_d;
      sq_im_q <= sq_im_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Sum peaks at 2^31 for (-32768,-32768): no overflow in 32 bits
  assign out_sum   = sq_re_q + sq_im_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Finds the bin with the largest |X|^2 in each 16-bin FFT frame and reports
// its index and magnitude with a one-cycle done pulse.
module fft_peak_detect #(
  parameter int LOG2_BINS = fft_peak_detect_pkg::LOG2_BINS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_valid,
  input  logic [31:0]          fft_d_in,
  output logic                 done,
  output logic [LOG2_BINS-1:0] freq,
  output logic [31:0]          peak_mag,
  output logic                 busy
);
  import fft_peak_detect_pkg::*;

  localparam logic [LOG2_BINS-1:0] LAST_IDX = '1;

  state_t state_q, state_d;

  logic [LOG2_BINS-1:0] cnt_d, cnt_q;
  logic [31:0]          max_val_d, max_val_q;
  logic [LOG2_BINS-1:0] max_idx_d, max_idx_q;
  logic                 fin_d, fin_q;
  logic                 done_d, done_q;
  logic [LOG2_BINS-1:0] freq_d, freq_q;
  logic [31:0]          peak_d, peak_q;

  logic                 s1_valid;
  logic [LOG2_BINS-1:0] s1_idx;
  logic                 s1_last;
  logic [31:0]          s1_sum;

  fft_mag_sq #(
    .IDX_W(LOG2_BINS)
  ) u_mag_sq (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fft_valid),
    .in_data  (fft_d_in),
    .in_idx   (cnt_q),
    .in_last  (cnt_q == LAST_IDX),
    .out_valid(s1_valid),
    .out_idx  (s1_idx),
    .out_last (s1_last),
    .out_sum  (s1_sum)
  );

  always_comb begin
    cnt_d     = cnt_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    freq_d    = freq_q;
    peak_d    = peak_q;
    if (fft_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Bin 0 restarts the running max; strict compare keeps the lowest index on ties
    if (s1_valid && ((s1_idx == '0) || (s1_sum > max_val_q))) begin
      max_val_d = s1_sum;
      max_idx_d = s1_idx;
    end
    fin_d  = s1_valid && s1_last;
    done_d = fin_q;
    // max_*_q holds the finished winner here even if the next frame's bin 0 is loading
    if (fin_q) begin
      freq_d = max_idx_q;
      peak_d = max_val_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fft_valid) state_d = COLLECT;
      COLLECT: if (fft_valid && (cnt_q == LAST_IDX)) state_d = FLUSH;
      FLUSH: begin
        if (fft_valid) begin
          state_d = COLLECT;
        end else if (fin_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      fin_q     <= 1'b0;
      done_q    <= 1'b0;
      freq_q    <= '0;
      peak_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      fin_q     <= fin_d;
      done_q    <= done_d;
      freq_q    <= freq_d;
      peak_q    <= peak_d;
    end
  end

  assign done     = done_q;
  assign freq     = freq_q;
  assign peak_mag = peak_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed frames for fft_peak_detect; expected results are queued when bin 15
// is driven and popped when done pulses.
module tb_fft_peak_detect;
  import fft_peak_detect_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] fft_d_in = '0;
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_mag;
  logic        busy;

  fft_peak_detect #(.LOG2_BINS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .fft_valid(fft_valid),
    .fft_d_in (fft_d_in),
    .done     (done),
    .freq     (freq),
    .peak_mag (peak_mag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] m;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [3:0]  hold_f = '0;
  logic [31:0] hold_m = '0;
  logic [31:0] frm[FFT_BINS];

  function automatic logic [31:0] mag(input logic [31:0] w);
    logic signed [15:0] r16;
    logic signed [15:0] i16;
    longint r;
    longint i;
    r16 = w[31:16];
    i16 = w[15:0];
    r = longint'(r16);
    i = longint'(i16);
    return 32'(r * r + i * i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs every cycle: matches done pulses against the scoreboard and checks holds
  task automatic observe();
    exp_t e;
    if (rst) begin
      hold_f = '0;
      hold_m = '0;
    end else if (done === 1'b1) begin
      done_cnt++;
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("freq", 32'(freq), 32'(e.f));
        chk("peak_mag", peak_mag, e.m);
        chk("done_latency", 32'(cyc), 32'(e.c));
        hold_f = e.f;
        hold_m = e.m;
      end
    end else begin
      chk("freq_hold", 32'(freq), 32'(hold_f));
      chk("peak_hold", peak_mag, hold_m);
      if (sb.size() > 0 && cyc > sb[0].c) begin
        chk("done_missing_at", 32'(cyc), 32'(sb[0].c));
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    observe();
    rst       = r;
    fft_valid = v;
    fft_d_in  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic send_frame(input int max_gap);
    logic [31:0] best;
    logic [3:0]  bi;
    best = mag(frm[0]);
    bi   = '0;
    for (int i = 1; i < FFT_BINS; i++) begin
      if (mag(frm[i]) > best) begin
        best = mag(frm[i]);
        bi   = 4'(i);
      end
    end
    for (int i = 0; i < FFT_BINS; i++) begin
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
      drive(1'b1, frm[i], 1'b0);
      if (i == FFT_BINS - 1) sb.push_back('{bi, best, cyc + 3});
      if (i == 8) begin
        #1;
        chk("busy_mid_frame", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic fill_random();
    logic [15:0] r;
    logic [15:0] i;
    for (int k = 0; k < FFT_BINS; k++) begin
      r = 16'($urandom_range(0, 200)) - 16'd100;
      i = 16'($urandom_range(0, 200)) - 16'd100;
      frm[k] = {r, i};
    end
  endtask

  initial begin
    // Reset with fft_valid asserted: must be ignored
    drive(1'b1, 32'h7FFF_7FFF, 1'b1);
    drive(1'b1, 32'h1234_5678, 1'b1);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_freq", 32'(freq), 32'd0);
    chk("rst_peak", peak_mag, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    idle(2);

    // Single tone at bin 5
    foreach (frm[k]) frm[k] = 32'h0;
    frm[5] = {16'd1000, 16'd0};
    send_frame(0);
    idle(5);
    #1;
    chk("busy_after_tone", 32'(busy), 32'd0);

    // Tie between bins 3 and 9: lower index wins
    foreach (frm[k]) frm[k] = {16'd10, 16'd10};
    frm[3] = {16'd0, 16'hFF38};
    frm[9] = {16'd0, 16'hFF38};
    send_frame(0);
    idle(4);

    // Most negative sample in bin 15: 2^31, no wrap
    foreach (frm[k]) frm[k] = 32'h0;
    frm[0]  = {16'd7, 16'd0};
    frm[15] = 32'h8000_8000;
    send_frame(0);
    idle(4);

    // Frame A with random gaps, then frame B back-to-back
    fill_random();
    frm[2] = {16'd5000, 16'hF448};
    send_frame(3);
    fill_random();
    frm[12] = {16'hF060, 16'd4000};
    send_frame(0);
    idle(5);

    // Reset after bin 7 discards the partial frame
    foreach (frm[k]) frm[k] = 32'h0;
    frm[3] = {16'd20000, 16'd0};
    for (int k = 0; k < 8; k++) drive(1'b1, frm[k], 1'b0);
    drive(1'b1, 32'h7FFF_7FFF, 1'b1);
    #1;
    chk("busy_in_rst", 32'(busy), 32'd0);
    chk("done_in_rst", 32'(done), 32'd0);
    drive(1'b1, 32'h7FFF_7FFF, 1'b1);
    #1;
    chk("busy_in_rst2", 32'(busy), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    idle(1);
    foreach (frm[k]) frm[k] = {16'd1, 16'd1};
    frm[1] = {16'd300, 16'd400};
    send_frame(0);
    idle(6);

    #1;
    chk("done_count", 32'(done_cnt), 32'd6);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
